// File: rtl/divider_simple.sv
// divider_simple: sequential restoring divider, one quotient bit per clock, start/busy/done handshake
package multipler_pkg;
  localparam int DATA_LENGTH = 64;
  localparam int LENGTH = 16;
  typedef enum logic [1:0] {IDLE, INIT, COMPUTE, FINISH} state_t;
  typedef logic [LENGTH-1:0] counter_t;
endpackage

module divider_simple
  import multipler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] dividend_i,
  input  logic [DATA_LENGTH-1:0] divisor_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_LENGTH-1:0] quotient_o,
  output logic [DATA_LENGTH-1:0] remainder_o,
  output logic                   div_by_zero_o
);
  state_t state;
  counter_t counter;
  logic [DATA_LENGTH-1:0] a, b, rem, quo, den, rem_next, quo_next;
  logic [DATA_LENGTH:0] shifted, trial;
  // one extra bit keeps the carry when den exceeds half the range
  always_comb begin
    shifted = {rem, quo[DATA_LENGTH-1]};
    trial = shifted - {1'b0, den};
    rem_next = trial[DATA_LENGTH] ? shifted[DATA_LENGTH-1:0] : trial[DATA_LENGTH-1:0];
    quo_next = {quo[DATA_LENGTH-2:0], ~trial[DATA_LENGTH]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      counter <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      div_by_zero_o <= 1'b0;
      quotient_o <= '0;
      remainder_o <= '0;
      a <= '0;
      b <= '0;
      rem <= '0;
      quo <= '0;
      den <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          a <= dividend_i;
          b <= divisor_i;
          busy_o <= 1'b1;
          state <= INIT;
        end
        INIT: begin
          rem <= '0;
          quo <= a;
          den <= b;
          counter <= '0;
          quotient_o <= (b == '0) ? '1 : '0;
          remainder_o <= (b == '0) ? a : '0;
          div_by_zero_o <= (b == '0);
          done_o <= (b == '0);
          state <= (b == '0) ? FINISH : COMPUTE;
        end
        COMPUTE: begin
          rem <= rem_next;
          quo <= quo_next;
          counter <= counter + 1'b1;
          if (counter == counter_t'(DATA_LENGTH - 1)) begin
            quotient_o <= quo_next;
            remainder_o <= rem_next;
            done_o <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider_simple.sv
// tb_divider_simple: randomized and directed checks of divider_simple against plain a/b, a%b arithmetic
module tb_divider_simple;
  import multipler_pkg::*;
  localparam int DL = DATA_LENGTH;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [DL-1:0] dividend_i = '0, divisor_i = '0;
  logic busy_o, done_o, div_by_zero_o;
  logic [DL-1:0] quotient_o, remainder_o;
  int n_pass = 0, n_chk = 0;

  always #5 clk = ~clk;

  divider_simple dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .done_o(done_o), .quotient_o(quotient_o), .remainder_o(remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  task automatic check(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DL-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic issue(input logic [DL-1:0] a, input logic [DL-1:0] b);
    @(negedge clk);
    dividend_i = a;
    divisor_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    dividend_i = rnd64();
    divisor_i = rnd64();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_q"}, quotient_o, 0);
    check({tag, "_r"}, remainder_o, 0);
    check({tag, "_dz"}, div_by_zero_o, 0);
  endtask

  // called just after the accept edge; poke > 0 pulses start_i with other operands at that cycle
  task automatic wait_result(input logic [DL-1:0] a, input logic [DL-1:0] b, input int poke);
    logic [DL-1:0] q, r;
    logic dz;
    int lat;
    int c = 0;
    bit busy_bad = 0;
    dz = (b == 0);
    q = dz ? '1 : a / b;
    r = dz ? a : a % b;
    lat = dz ? 2 : DL + 2;
    do begin
      @(negedge clk);
      c++;
      if (!busy_o) busy_bad = 1;
      if (c == poke) begin
        start_i = 1'b1;
        dividend_i = rnd64();
        divisor_i = rnd64();
      end
      if (poke > 0 && c == poke + 1) start_i = 1'b0;
    end while (!done_o && c < 200);
    check("latency", DL'(c), DL'(lat));
    check("busy", busy_bad, 0);
    check("quotient", quotient_o, q);
    check("remainder", remainder_o, r);
    check("div_by_zero", div_by_zero_o, dz);
    if (!dz) begin
      check("identity", quotient_o * b + remainder_o, a);
      check("rem_lt_div", remainder_o < b, 1);
    end
    @(negedge clk);
    check("done_pulse", done_o, 0);
  endtask

  task automatic op(input logic [DL-1:0] a, input logic [DL-1:0] b);
    issue(a, b);
    wait_result(a, b, -1);
  endtask

  initial begin
    logic [DL-1:0] a, b;
    bit seen;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    op(100, 7);
    op(64'hDEAD, 0);
    op('1, 1);
    op(5, 9);
    op('1, 64'h8000_0000_0000_0001);

    issue(5000, 17);
    wait_result(5000, 17, 20);
    repeat (3) @(negedge clk);
    check("ignored_busy", busy_o, 0);
    check("ignored_done", done_o, 0);

    // start held high: the second init must follow done by exactly two cycles
    @(negedge clk);
    dividend_i = 64'd123456789;
    divisor_i = 64'd1000;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    wait_result(64'd123456789, 64'd1000, -1);
    check("gap_idle", busy_o, 0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_result(64'd123456789, 64'd1000, -1);

    issue(64'hFFFF_0000_1234_5678, 64'd97);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_o || busy_o) seen = 1;
    end
    check("rst_quiet", seen, 0);
    op(1000, 33);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: begin a = rnd64(); b = 0; end
        1: begin b = rnd64() | 1; a = rnd64() % b; end
        2: begin a = rnd64(); b = DL'($urandom_range(1, 255)); end
        3: begin a = rnd64(); b = rnd64() >> $urandom_range(0, 63); end
        default: begin a = rnd64(); b = rnd64() | 64'h8000_0000_0000_0000; end
      endcase
      op(a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
